// File: rtl/aes_key_expander.sv
// AES-128/AES-256 round-key schedule generator with a 15-entry key memory.
// The S-box is external: sboxw goes out, new_sboxw comes back in the same cycle.
module aes_key_expander #(
    parameter logic [3:0] AES128_ROUNDS = 4'ha,
    parameter logic [3:0] AES256_ROUNDS = 4'he
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         keylen,
    input  logic [255:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    localparam int unsigned NUM_KEYS = 15;
    localparam logic [7:0]  RCON_INIT = 8'h8d;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_GEN
    } state_t;

    state_t         state_q, state_d;
    logic [255:0]   key_q, key_d;
    logic           keylen_q, keylen_d;
    logic [3:0]     ctr_q, ctr_d;
    logic [7:0]     rcon_q, rcon_d;
    logic           ready_q, ready_d;
    logic [127:0]   mem_q [NUM_KEYS];
    logic [127:0]   mem_d [NUM_KEYS];

    logic [127:0]   prev1, prev0, base;
    logic [3:0]     idx1, idx0, last_round;
    logic           rot_en;
    logic [31:0]    w3, sub_in, t;
    logic [7:0]     rcon_adv;
    logic [31:0]    n0, n1, n2, n3;

    // Fetch the two previous round keys for the entry being generated.
    always_comb begin
        idx1  = ctr_q - 4'd1;
        idx0  = ctr_q - 4'd2;
        prev1 = '0;
        prev0 = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (idx1 == 4'(i)) prev1 = mem_q[i];
            if (idx0 == 4'(i)) prev0 = mem_q[i];
        end
    end

    // Round-key word arithmetic: rotation/rcon only on key-length-aligned entries.
    always_comb begin
        rot_en     = !keylen_q || !ctr_q[0];
        w3         = prev1[31:0];
        sub_in     = rot_en ? {w3[23:0], w3[31:24]} : w3;
        rcon_adv   = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        t          = rot_en ? (new_sboxw ^ {rcon_adv, 24'h0}) : new_sboxw;
        base       = keylen_q ? prev0 : prev1;
        n0         = base[127:96] ^ t;
        n1         = base[95:64]  ^ n0;
        n2         = base[63:32]  ^ n1;
        n3         = base[31:0]   ^ n2;
        last_round = keylen_q ? AES256_ROUNDS : AES128_ROUNDS;
    end

    // Shared S-box request is only live while generating.
    assign sboxw = (state_q == ST_GEN) ? sub_in : 32'h0;
    assign ready = ready_q;

    // Combinational key-memory read; index 15 reads as zero.
    always_comb begin
        round_key = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (round == 4'(i)) round_key = mem_q[i];
        end
    end

    // Next-state and memory-write logic.
    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        keylen_d = keylen_q;
        ctr_d    = ctr_q;
        rcon_d   = rcon_q;
        ready_d  = ready_q;
        mem_d    = mem_q;
        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    key_d    = key;
                    keylen_d = keylen;
                    ready_d  = 1'b0;
                    state_d  = ST_INIT;
                end
            end
            ST_INIT: begin
                mem_d[0] = key_q[255:128];
                if (keylen_q) mem_d[1] = key_q[127:0];
                ctr_d   = keylen_q ? 4'd2 : 4'd1;
                rcon_d  = RCON_INIT;
                state_d = ST_GEN;
            end
            ST_GEN: begin
                for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                    if (ctr_q == 4'(i)) mem_d[i] = {n0, n1, n2, n3};
                end
                if (rot_en) rcon_d = rcon_adv;
                if (ctr_q == last_round) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ctr_d = ctr_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, control and key-memory registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            key_q    <= '0;
            keylen_q <= 1'b0;
            ctr_q    <= '0;
            rcon_q   <= RCON_INIT;
            ready_q  <= 1'b1;
            for (int unsigned i = 0; i < NUM_KEYS; i++) mem_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            keylen_q <= keylen_d;
            ctr_q    <= ctr_d;
            rcon_q   <= rcon_d;
            ready_q  <= ready_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Scoreboard bench for aes_key_expander against a word-level FIPS-197 key schedule model.
module tb_aes_key_expander;

    logic         clk;
    logic         reset;
    logic         init;
    logic         keylen;
    logic [255:0] key;
    logic [3:0]   rnd;
    logic [127:0] round_key;
    logic         ready;
    logic [31:0]  sboxw;
    logic [31:0]  new_sboxw;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic              is_zero;
        logic [7:0]        lat;
        logic [15:0][127:0] rk;
        logic [15:0][31:0]  sbx;
    } rec_t;

    rec_t         exp_q [$];
    logic [127:0] model_mem [15];
    logic [31:0]  model_sbx [16];

    aes_key_expander dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .keylen    (keylen),
        .key       (key),
        .round     (rnd),
        .round_key (round_key),
        .ready     (ready),
        .sboxw     (sboxw),
        .new_sboxw (new_sboxw)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // GF(2^8) helpers; the S-box is derived from inversion plus the affine map.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            b = b >> 1;
            a = xtime(a);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        logic [7:0] inv, base, s;
        inv  = 8'h01;
        base = x;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) inv = gmul(inv, base);
            base = gmul(base, base);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]), sbox_byte(w[15:8]), sbox_byte(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Shared S-box seen by the DUT.
    assign new_sboxw = sub_word(sboxw);

    // Textbook word-indexed key expansion; also derives the S-box request per GEN cycle.
    task automatic model_expand(input logic kl, input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        int nk, nr, first;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            temp = w[i-1];
            if (i % nk == 0) begin
                temp = sub_word(rot_word(temp)) ^ {rc, 24'h0};
                rc   = xtime(rc);
            end else if (nk == 8 && i % nk == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-nk] ^ temp;
        end
        for (int r = 0; r <= nr; r++) model_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        for (int i = 0; i < 16; i++) model_sbx[i] = '0;
        first = kl ? 2 : 1;
        for (int c = first; c <= nr; c++) begin
            model_sbx[c - first + 1] = (!kl || c % 2 == 0) ? rot_word(w[4*c-1]) : w[4*c-1];
        end
    endtask

    task automatic push_expand(input logic kl, input logic [255:0] k, input int spec_id);
        rec_t r;
        model_expand(kl, k);
        r = '0;
        r.lat = kl ? 8'd14 : 8'd11;
        for (int i = 0; i < 15; i++) r.rk[i] = model_mem[i];
        for (int i = 0; i < 16; i++) r.sbx[i] = model_sbx[i];
        if (spec_id == 1) begin
            r.rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
            r.rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
            r.rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        end else if (spec_id == 2) begin
            r.rk[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
            r.rk[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
            r.rk[14] = 128'hfe4890d1e6188d0b046df344706c631e;
        end
        exp_q.push_back(r);
    endtask

    task automatic push_zero();
        rec_t r;
        r = '0;
        r.is_zero = 1'b1;
        for (int i = 0; i < 15; i++) model_mem[i] = '0;
        exp_q.push_back(r);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reads every round index within the low clock phase and compares.
    task automatic sweep(input rec_t r);
        chk("ready_idle", 128'(ready), 128'(1'b1));
        chk("sboxw_idle", 128'(sboxw), 128'h0);
        for (int i = 0; i < 16; i++) begin
            rnd = 4'(i);
            #1;
            chk($sformatf("round_key[%0d]", i), round_key, r.rk[i]);
        end
    endtask

    // Monitor: pops an expectation when the DUT goes busy or after a reset release.
    initial begin : monitor
        rec_t cur;
        bit   busy;
        int   k;
        busy = 1'b0;
        k    = 0;
        cur  = '0;
        rnd  = 4'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                busy = 1'b0;
            end else begin
                if (!busy && exp_q.size() > 0 && exp_q[0].is_zero) begin
                    cur = exp_q.pop_front();
                    sweep(cur);
                end else if (!busy && !ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_start: got busy expected idle");
                    end else begin
                        cur  = exp_q.pop_front();
                        busy = 1'b1;
                        k    = 0;
                    end
                end
                if (busy) begin
                    if (!ready) begin
                        if (k < 16) chk($sformatf("sboxw[%0d]", k), 128'(sboxw), 128'(cur.sbx[k]));
                        k++;
                        if (k > 40) begin
                            checks++;
                            errors++;
                            $display("FAIL busy_timeout: got %0d cycles expected %0d", k, cur.lat);
                            busy = 1'b0;
                        end
                    end else begin
                        chk("latency", 128'(k), 128'(cur.lat));
                        sweep(cur);
                        busy = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Issue a one-cycle init, then scramble key/keylen to show they are not re-sampled.
    task automatic start(input logic kl, input logic [255:0] k, input int spec_id);
        @(negedge clk);
        init   = 1'b1;
        keylen = kl;
        key    = k;
        push_expand(kl, k, spec_id);
        @(negedge clk);
        init   = 1'b0;
        keylen = 1'($urandom());
        key    = rand_key();
    endtask

    task automatic wait_done();
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (ready) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got no ready within 100 cycles expected ready");
    endtask

    localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    initial begin : stimulus
        logic [255:0] k;
        reset  = 1'b1;
        init   = 1'b0;
        keylen = 1'b0;
        key    = '0;
        for (int i = 0; i < 15; i++) model_mem[i] = '0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        push_zero();

        // Known-answer vectors.
        start(1'b0, KEY128, 1);
        wait_done();
        start(1'b1, KEY256, 2);
        wait_done();

        // init pulse with different key/keylen while generating is ignored.
        start(1'b0, KEY128, 1);
        repeat (3) @(negedge clk);
        init   = 1'b1;
        keylen = 1'b1;
        key    = rand_key();
        @(negedge clk);
        init   = 1'b0;
        wait_done();

        // Reset during GEN clears everything; a fresh AES-128 run reproduces the vector.
        start(1'b0, rand_key(), 0);
        repeat (5) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1 reset = 1'b0;
        push_zero();
        start(1'b0, KEY128, 1);
        wait_done();

        // Back-to-back AES-128 then AES-256, then random alternation.
        start(1'b0, rand_key(), 0);
        wait_done();
        start(1'b1, KEY256, 2);
        wait_done();
        for (int i = 0; i < 6; i++) begin
            start(1'($urandom()), rand_key(), 0);
            wait_done();
        end

        // init held high: expansion restarts right after completion.
        k = rand_key();
        @(negedge clk);
        init   = 1'b1;
        keylen = 1'b0;
        key    = k;
        push_expand(1'b0, k, 0);
        wait_done();
        push_expand(1'b0, k, 0);
        @(negedge clk);
        init = 1'b0;
        wait_done();

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
